// File: rtl/rotating_square_if.sv
// Display-side bundle for rotating_square: step controls in, multiplexed
// seven-segment drive and debug position out.
interface rotating_square_if;
  logic       tick;
  logic       en;
  logic       cw;
  logic [3:0] an;
  logic [6:0] seg;
  logic [2:0] pos;

  modport master (output tick, en, cw, input an, seg, pos);
  modport slave  (input tick, en, cw, output an, seg, pos);
endinterface

// File: rtl/rotating_square.sv
// Walks an upper/lower square around a 4-digit multiplexed seven-segment
// display, one position per rising edge of the slow tick input.
module rotating_square #(
  parameter int REFRESH_BITS = 18
) (
  input  logic             clk,
  input  logic             reset,
  rotating_square_if.slave bus
);

  logic                    tick_q;
  logic [2:0]              pos_q;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [3:0]              an_q;
  logic [6:0]              seg_q;
  logic [1:0]              sel;
  logic [1:0]              target;
  logic                    step;

  assign sel    = refresh_cnt[REFRESH_BITS-1 -: 2];
  assign target = pos_q[2] ? pos_q[1:0] : (2'd3 - pos_q[1:0]);
  assign step   = bus.tick & ~tick_q & bus.en;

  // tick_q resets high so a tick already high at release is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q      <= 1'b1;
      pos_q       <= 3'd0;
      refresh_cnt <= '0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
    end else begin
      tick_q      <= bus.tick;
      refresh_cnt <= refresh_cnt + 1'b1;
      if (step) begin
        if (bus.cw) pos_q <= pos_q + 3'd1;
        else        pos_q <= pos_q - 3'd1;
      end
      an_q <= ~(4'b0001 << sel);
      if (sel == target) seg_q <= pos_q[2] ? 7'b0100011 : 7'b0011100;
      else               seg_q <= 7'b1111111;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.pos = pos_q;

endmodule

// File: tb/tb_rotating_square.sv
// Randomized and directed bench for rotating_square against a behavioural
// model of the square's position and the display multiplexing.
module tb_rotating_square;
  localparam int RB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  rotating_square_if bus ();

  rotating_square #(.REFRESH_BITS(RB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural reference: cycle count, position and last-seen tick level
  int         m_cnt;
  int         m_pos;
  logic       m_tick_prev;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  function automatic logic [6:0] exp_seg(input int p, input int s);
    int digit;
    digit = (p < 4) ? (3 - p) : (p - 4);
    if (s != digit) return 7'h7F;
    return (p >= 4) ? 7'b0100011 : 7'b0011100;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_pos = 0; m_tick_prev = 1'b1;
      m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      int s;
      s = (m_cnt / (1 << (RB - 2))) % 4;
      m_an  = 4'hF ^ 4'(1 << s);
      m_seg = exp_seg(m_pos, s);
      m_cnt = (m_cnt + 1) % (1 << RB);
      if (bus.tick && !m_tick_prev && bus.en)
        m_pos = bus.cw ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
      m_tick_prev = bus.tick;
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_an",  bus.an,  m_an);
      chk("model_seg", bus.seg, m_seg);
      chk("model_pos", bus.pos, m_pos);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_edge();
    bus.tick = 1'b0; cyc(2);
    bus.tick = 1'b1; cyc(2);
  endtask

  task automatic scan(input logic [3:0] act_an, input logic [6:0] pat);
    repeat (8) begin
      @(negedge clk);
      chk("scan_seg", bus.seg, (bus.an == act_an) ? pat : 7'h7F);
    end
  endtask

  initial begin
    logic [3:0] ea;
    bit found;
    bus.tick = 1'b1; bus.en = 1'b1; bus.cw = 1'b1;

    // 1: reset hold, release with tick high
    cyc(3);
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_pos", bus.pos, 0);
    chk_on = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ea = 4'hF ^ 4'(1 << (i / 4));
      chk("walk_an", bus.an, ea);
      chk("walk_pos", bus.pos, 0);
    end

    // 2: nine forward steps
    scan(4'b0111, 7'b0011100);
    for (int i = 0; i < 9; i++) begin
      tick_edge();
      chk("fwd_pos", bus.pos, (i + 1) % 8);
      if (i == 3) scan(4'b1110, 7'b0100011);
    end

    // 3: backward from 0 to 7
    bus.cw = 1'b0;
    tick_edge();
    chk("back_pos0", bus.pos, 0);
    tick_edge();
    chk("back_pos7", bus.pos, 7);
    scan(4'b0111, 7'b0100011);
    scan(4'b0111, 7'b0100011);

    // 4: edges dropped while disabled, no step on enable with tick high
    bus.en = 1'b0;
    repeat (3) tick_edge();
    chk("dis_pos", bus.pos, 7);
    bus.en = 1'b1; cyc(5);
    chk("en_hi_pos", bus.pos, 7);
    bus.cw = 1'b1;
    tick_edge();
    chk("en_step_pos", bus.pos, 0);

    // 5: long high tick gives one step; cw toggles alone never step
    bus.tick = 1'b0; cyc(2);
    bus.tick = 1'b1; cyc(20);
    chk("long_hi_pos", bus.pos, 1);
    for (int i = 0; i < 6; i++) begin bus.cw = ~bus.cw; cyc(1); end
    chk("cw_tog_pos", bus.pos, 1);

    // 6: async reset mid-sweep at pos 5 while its digit is lit
    bus.cw = 1'b1;
    for (int i = 0; i < 8 && bus.pos != 3'd5; i++) tick_edge();
    chk("pre_rst_pos", bus.pos, 5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.an == 4'b1101) found = 1'b1;
    end
    chk("find_digit", found, 1);
    chk("lit_seg", bus.seg, 7'b0100011);
    #2 reset = 1'b0;
    #1;
    chk("async_an", bus.an, 4'hF);
    chk("async_seg", bus.seg, 7'h7F);
    chk("async_pos", bus.pos, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("restart_an", bus.an, 4'b1110);

    // random phase
    for (int k = 0; k < 400; k++) begin
      bus.en   = ($urandom_range(0, 3) != 0);
      bus.cw   = $urandom_range(0, 1);
      bus.tick = ~bus.tick;
      cyc($urandom_range(1, 6));
      if ($urandom_range(0, 49) == 0) begin
        #3 reset = 1'b0;
        cyc(2);
        reset = 1'b1;
      end
    end
    cyc(2);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rotating_square.md
Name: rotating_square

Overview:
- Consumes the slow `tick` square wave from the LED-rate clock divider and advances a square around a 4-digit multiplexed seven-segment display.
- An upper square (segments a,b,f,g) travels left to right across the digits, then a lower square (segments c,d,e,g) travels right to left, for 8 positions in a loop.
- The block also time-multiplexes the anodes and drives the active-low display pins directly.

Parameters:
- REFRESH_BITS, 18, width of the free-running refresh counter. Its top 2 bits select the active digit. Benches use 4.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to clk.
- tick  input  1  level square wave from the divider; each rising edge is one step request.
- en  input  1  1 = steps allowed; 0 = position frozen while the display keeps refreshing.
- cw  input  1  1 = step forward (position +1), 0 = step backward (position -1).
- an  output  4  active-low digit anodes. an[3] is the leftmost digit, an[0] the rightmost.
- seg  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- pos  output  3  current position, for debug and verification.

Behaviour:
- Reset (reset=0), asynchronous:
  - pos=0, refresh counter=0, tick_q=1, an=4'b1111, seg=7'h7F.
  - tick_q resets to 1 so a tick that is already high at reset release does not cause a step.
- Edge detect:
  - tick_q <= tick every cycle.
  - step = tick & ~tick_q & en, at most one per rising edge of tick.
  - tick is already synchronous to clk; no synchronizer is required.
- Position register, 3 bits:
  - On step with cw=1: pos <= pos+1 (wraps 7->0).
  - On step with cw=0: pos <= pos-1 (wraps 0->7).
  - en=0 during a rising edge drops that edge; it is not queued.
  - cw is sampled in the same cycle as step. A cw change never causes a step by itself.
- Position map:
  - pos 0..3: upper square on digits 3,2,1,0 respectively.
  - pos 4..7: lower square on digits 0,1,2,3 respectively.
  - target digit = pos[2] ? pos[1:0] : 3-pos[1:0].
- Refresh:
  - The REFRESH_BITS-wide counter increments every cycle and wraps freely.
  - sel = counter[REFRESH_BITS-1 -: 2].
- Output stage (registered, one-cycle latency from sel/pos):
  - an <= ~(4'b0001 << sel).
  - seg <= (sel == target digit) ? (pos[2] ? 7'b0100011 : 7'b0011100) : 7'b1111111.
  - Exactly one an bit is low at all times after the first post-reset clock.
  - A pos change shows on seg on the next clock.
- Simultaneous events:
  - A step and a sel change in the same cycle are both applied. The output register sees old pos/sel that cycle and new values the next.
- Reset mid-operation:
  - Outputs are forced immediately to the reset values: blank display, all anodes off.
  - Position returns to 0.
- No other state exists; there are no illegal states (pos and sel are fully decoded).

Test Plan:
1. Reset hold, then release with tick=1, en=1 -> pos stays 0, no step; an=1111 and seg=7F during reset; after release an walks 1110, 1101, 1011, 0111 every 4 clocks (REFRESH_BITS=4).
2. en=1, cw=1, 9 rising edges on tick -> pos sequence 1..7,0,1. When an=0111 at pos=0, seg=7'b0011100. At pos=4, seg=7'b0100011 only while an=1110.
3. cw=0 from pos=0, one tick edge -> pos=7; lower square on digit 3 (an=0111, seg=0100011), all other digits 7F.
4. en=0 across 3 tick edges, then en=1 with tick held high -> pos unchanged; no step until the next 0->1 tick transition.
5. tick held high for 20 clocks -> exactly one step. Toggling cw with tick static -> no step.
6. Assert reset mid-sweep at pos=5 during an active digit -> an=1111 and seg=7F in the same cycle; after release pos=0 and the refresh sequence restarts at an=1110.
